memoria_rf: RTL
===============

Name: memoria_rf

Overview:
- Parametrised register file for the proyecto-1 datapath. It is the next generation of the 16x16 preset register bank.
- Width and depth are configurable. It has one write port and two registered read ports with write-first bypass.
- Storage is cleared after reset by a sequential sweep rather than a per-flop reset, so the array can be inferred as RAM.
- It sits between the control unit (write side) and the ALU operand muxes (read side).

Parameters:
- N, 16, data width in bits (N >= 1).
- DEPTH, 16, number of registers (2..256, need not be a power of two).
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- w  in  1  write enable; sampled only when busy=0.
- waddr  in  AW  write address.
- s  in  N  write data.
- rd  in  1  read request for both ports.
- ra  in  AW  read address, port A.
- rb  in  AW  read address, port B.
- qa  out  N  read data, port A (registered).
- qb  out  N  read data, port B (registered).
- rvalid  out  1  qa/qb valid; one-cycle pulse per accepted rd.
- busy  out  1  high while the init sweep runs.

Behaviour:
- FSM states: INIT, READY. Reset (rst=1 at a clk edge) forces state INIT and idx=0, independent of any other input.
- Reset values: qa=0, qb=0, rvalid=0, busy=1.
- Reset is honoured mid-sweep and in READY; the sweep always restarts at idx 0.
- INIT behaviour:
  - Each cycle writes 0 to entry idx and increments idx.
  - On the cycle that writes idx=DEPTH-1, the state becomes READY next cycle. The sweep takes exactly DEPTH cycles after reset deasserts.
  - busy=1 throughout. w and rd are ignored: no write, rvalid stays 0, qa/qb hold 0.
- READY behaviour:
  - busy=0.
  - If w=1 and waddr<DEPTH, mem[waddr]<=s at the edge. If waddr>=DEPTH, the write is dropped silently.
- Read path:
  - When rd=1 in READY, the edge captures qa<=mem[ra] and qb<=mem[rb], and rvalid=1 in the following cycle. Latency is 1 cycle.
  - When rd=0, rvalid<=0 and qa/qb hold their last values.
- Bypass: if rd=1, w=1 and waddr==ra (or rb) in the same cycle, that port returns s (write-first). Both ports can bypass simultaneously.
- Out-of-range read (ra or rb >= DEPTH) returns 0 on that port; rvalid still pulses.
- Back-to-back reads: one read per cycle, fully pipelined, no stalls.
- Width: s is stored unmodified. There is no sign extension or arithmetic.

Optional Feature:
- Macro: MEMORIA_RF_ZERO_REG_EN.
- When defined:
  - Entry 0 is hardwired to zero; writes to address 0 are dropped.
  - Reads of address 0 return 0 even when bypass conditions match.
- When undefined, entry 0 is an ordinary register.

Decomposition:
- Package memoria_pkg holds:
  - The state typedef (INIT, READY).
  - A default-width constant (16) and default-depth constant (16).
  - A function computing the legal-address check.
- One natural sub-module, memoria_rf_init: the sweep FSM plus idx counter. It outputs busy, the init write enable, the init address and the done strobe.
- Storage and read ports stay in memoria_rf.

Test Plan:
- Reset sweep: with DEPTH=16, deassert rst → busy=1 for exactly 16 cycles, then 0. A read of every address afterwards returns 0x0000 with rvalid one cycle after rd.
- Write/readback: write 0x0042 to addr 3, then the next cycle rd with ra=3, rb=4 → qa=0x0042, qb=0x0000, rvalid=1 one cycle later.
- Bypass: same cycle w=1, waddr=5, s=0xBEEF, rd=1, ra=5, rb=5 → qa=qb=0xBEEF next cycle; a later read of 5 also returns 0xBEEF.
- Reset mid-operation: assert rst during sweep idx=7 and again in READY after writing 0x1234 to addr 2 → sweep restarts (busy 16 more cycles), addr 2 reads 0x0000, and qa/qb/rvalid are 0 during reset.
- Non-power-of-two: with DEPTH=12, N=8:
  - Writing 0xAA to addr 13 is dropped; reading addr 13 gives 0x00 with rvalid=1.
  - Writing 0x55 to addr 11 reads back 0x55.
- MEMORIA_RF_ZERO_REG_EN defined: write 0xFFFF to addr 0 with a same-cycle read of addr 0 → qa=0x0000; a later read of addr 0 also gives 0x0000.

Source files
------------

// File: rtl/memoria_pkg.sv
// memoria_pkg: shared types and helpers for the memoria_rf register file.
//   state_e    - init-sweep FSM states (StInit, StReady)
//   DefWidth   - default data width
//   DefDepth   - default number of entries
//   addr_legal - true when an address falls inside the populated range
package memoria_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 16;

  typedef enum logic {
    StInit,
    StReady
  } state_e;

  // Depth need not be a power of two, so the top address codes can be unpopulated.
  function automatic logic addr_legal(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/memoria_rf_init.sv
// memoria_rf_init: post-reset clearing sweep for memoria_rf.
// Walks idx from 0 to DEPTH-1, one entry per cycle, then parks in StReady.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset; restarts the sweep at idx 0
//   busy_o      - high while the sweep runs
//   init_we_o   - write strobe for the entry being cleared
//   init_addr_o - entry being cleared this cycle
//   done_o      - pulses on the cycle that clears the last entry
module memoria_rf_init
  import memoria_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy_o,
  output logic          init_we_o,
  output logic [AW-1:0] init_addr_o,
  output logic          done_o
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_o    = 1'b0;
    init_we_o = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      StInit: begin
        busy_o    = 1'b1;
        init_we_o = 1'b1;
        if (idx_q == LastIdx) begin
          done_o  = 1'b1;
          idx_d   = '0;
          state_d = StReady;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StReady: state_d = StReady;
    endcase
  end

  assign init_addr_o = idx_q;

endmodule

// File: rtl/memoria_rf.sv
// memoria_rf: parametrised register file, one write port, two registered read
// ports with write-first bypass. Storage has no per-entry reset; it is cleared by
// the memoria_rf_init sweep so the array can map onto RAM.
// Optional feature macro: MEMORIA_RF_ZERO_REG_EN (entry 0 reads as zero, writes
// to it are dropped, including on the bypass path).
// Ports:
//   clk, rst      - clock (rising edge), synchronous active-high reset
//   w, waddr, s   - write enable, address, data (ignored while busy)
//   rd, ra, rb    - read request and the two read addresses
//   qa, qb        - registered read data
//   rvalid        - one-cycle pulse, qa/qb valid
//   busy          - high while the clearing sweep runs
module memoria_rf
  import memoria_pkg::*;
#(
  parameter int unsigned N     = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  // Derived; do not override.
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  s,
  input  logic          rd,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [N-1:0]  qa,
  output logic [N-1:0]  qb,
  output logic          rvalid,
  output logic          busy
);

`ifdef MEMORIA_RF_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [N-1:0]  mem [DEPTH];
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic          init_done;
  logic          unused_done;
  logic          user_we;
  logic          rd_ok;
  logic [N-1:0]  rdata_a;
  logic [N-1:0]  rdata_b;

  memoria_rf_init #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_init (
    .clk        (clk),
    .rst        (rst),
    .busy_o     (busy),
    .init_we_o  (init_we),
    .init_addr_o(init_addr),
    .done_o     (init_done)
  );

  assign unused_done = init_done;

  assign user_we = !rst && !busy && w && addr_legal(32'(waddr), DEPTH) &&
                   !(ZeroReg && (waddr == '0));
  assign rd_ok   = rd && !busy;

  always_ff @(posedge clk) begin
    if (!rst && init_we) begin
      mem[init_addr] <= '0;
    end else if (user_we) begin
      mem[waddr] <= s;
    end
  end

  // Write-first: a same-cycle write to the read address wins over the array.
  always_comb begin
    rdata_a = '0;
    if (addr_legal(32'(ra), DEPTH) && !(ZeroReg && (ra == '0))) begin
      rdata_a = (w && (waddr == ra)) ? s : mem[ra];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (addr_legal(32'(rb), DEPTH) && !(ZeroReg && (rb == '0))) begin
      rdata_b = (w && (waddr == rb)) ? s : mem[rb];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qa     <= '0;
      qb     <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) begin
        qa <= rdata_a;
        qb <= rdata_b;
      end
    end
  end

endmodule
